// File: rtl/idli_tb_uart_rx_m.sv
// Bench UART receiver: 8N1 (8E1 with IDLI_TB_UART_RX_PARITY_EN), byte FIFO with valid/ready.
// Flags framing errors and FIFO overruns as single-cycle pulses.
module idli_tb_uart_rx_m #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_urx_gck,
  input  logic       i_urx_rst,
  input  logic       i_urx_rx,
  output logic       o_urx_valid,
  output logic [7:0] o_urx_data,
  input  logic       i_urx_ready,
  output logic       o_urx_frame,
  output logic       o_urx_ovr,
  output logic       o_urx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IDLI_TB_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [CW-1:0] clk_q, clk_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        frame_q, frame_d;
  logic        ovr_q, ovr_d;
  logic        push;
  logic        perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    frame_d = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_q == HALF) begin
          clk_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_q == LAST) begin
          clk_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          idx_d = idx_q + 1'b1;
`ifdef IDLI_TB_UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef IDLI_TB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_q == LAST) begin
          clk_d   = '0;
          perr_d  = rx_s_q ^ (^sh_q);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_q == LAST) begin
          clk_d = '0;
          if (rx_s_q) begin
            frame_d = perr_q;
            push    = !perr_q;
            state_d = S_IDLE;
          end else begin
            frame_d = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        clk_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_urx_gck) begin
    if (i_urx_rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      clk_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      perr_q    <= 1'b0;
      frame_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_urx_rx;
      rx_s_q    <= rx_meta_q;
      clk_q     <= clk_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      perr_q    <= perr_d;
      frame_q   <= frame_d;
      ovr_q     <= ovr_d;
    end
  end

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && i_urx_ready;
  assign wr_en = push && (!full || pop);
  assign ovr_d = push && full && !pop;

  always_ff @(posedge i_urx_gck) begin
    if (i_urx_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_urx_gck) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= sh_q;
  end

  assign o_urx_valid = !empty;
  assign o_urx_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign o_urx_frame = frame_q;
  assign o_urx_ovr   = ovr_q;
  assign o_urx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_idli_tb_uart_rx_m.sv
// Bench for idli_tb_uart_rx_m: scoreboard of expected bytes, popped as the DUT hands them over.
module tb_idli_tb_uart_rx_m;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       valid, frame, ovr, busy;
  logic [7:0] data;

  int checks = 0;
  int failures = 0;
  int frame_cnt = 0;
  int ovr_cnt = 0;
  int valid_cnt = 0;
  int rcv_cnt = 0;
  logic [7:0] exp_q[$];

  idli_tb_uart_rx_m #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_urx_gck  (clk),
    .i_urx_rst  (rst),
    .i_urx_rx   (rx),
    .o_urx_valid(valid),
    .o_urx_data (data),
    .i_urx_ready(ready),
    .o_urx_frame(frame),
    .o_urx_ovr  (ovr),
    .o_urx_busy (busy)
  );

  always #5 clk = ~clk;

  // Sample well away from the rising edge, after negedge-driven inputs settle.
  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (!rst) begin
      if (frame) frame_cnt++;
      if (ovr) ovr_cnt++;
      if (valid) valid_cnt++;
      if (valid && ready) begin
        rcv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h expected=none", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            failures++;
            $display("FAIL pop_data got=%h expected=%h", data, e);
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low,
                            input logic par);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef IDLI_TB_UART_RX_PARITY_EN
    drive_bit(par, CPB);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    if (stop_low > 0) drive_bit(1'b0, stop_low);
    drive_bit(1'b1, CPB);
  endtask

  function automatic logic epar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, want);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d expected=0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({valid, data, frame, ovr, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=000",
               {valid, data, frame, ovr, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_int("idle_valid", int'(valid), 0);
    check_int("idle_busy", int'(busy), 0);
  endtask

  task automatic test_basic();
    int v0 = valid_cnt, f0 = frame_cnt, o0 = ovr_cnt, r0 = rcv_cnt;
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 0, epar(8'hA5));
      begin
        repeat (20) @(negedge clk);
        #1 check_int("busy_mid_frame", int'(busy), 1);
      end
    join
    repeat (20) @(negedge clk);
    ready = 1'b0;
    check_int("basic_rcv", rcv_cnt - r0, 1);
    check_int("basic_valid_cycles", valid_cnt - v0, 1);
    check_int("basic_frame", frame_cnt - f0, 0);
    check_int("basic_ovr", ovr_cnt - o0, 0);
    check_int("basic_busy_end", int'(busy), 0);
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt, f0 = frame_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    check_int("glitch_valid", valid_cnt - v0, 0);
    check_int("glitch_frame", frame_cnt - f0, 0);
    check_int("glitch_busy", int'(busy), 0);
  endtask

  task automatic test_break();
    int f0 = frame_cnt, r0 = rcv_cnt;
    ready = 1'b1;
    send_frame(8'h3C, 40, epar(8'h3C));
    repeat (20) @(negedge clk);
    check_int("break_frame", frame_cnt - f0, 1);
    check_int("break_rcv", rcv_cnt - r0, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, epar(8'h11));
    repeat (20) @(negedge clk);
    check_int("break_next_rcv", rcv_cnt - r0, 1);
    check_int("break_q_empty", exp_q.size(), 0);
    ready = 1'b0;
  endtask

  task automatic test_overrun();
    int o0 = ovr_cnt;
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 0, epar(8'(i)));
    end
    repeat (10) @(negedge clk);
    check_int("ovr_pulses", ovr_cnt - o0, 1);
    check_int("ovr_valid_held", int'(valid), 1);
    drain("ovr");
  endtask

  task automatic test_push_pop_full();
    int o0;
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 0, epar(8'(i)));
    end
    o0 = ovr_cnt;
    exp_q.push_back(8'h06);
    fork
      send_frame(8'h06, 0, epar(8'h06));
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check_int("pp_ovr", ovr_cnt - o0, 0);
    check_int("pp_q_left", exp_q.size(), 4);
    drain("pp");
  endtask

  task automatic test_back_to_back();
    int r0 = rcv_cnt;
    ready = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    send_frame(8'h81, 0, epar(8'h81));
    send_frame(8'h7E, 0, epar(8'h7E));
    repeat (20) @(negedge clk);
    check_int("b2b_rcv", rcv_cnt - r0, 2);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int r0 = rcv_cnt;
    ready = 1'b1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, 6);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_int("rst_mid_busy", int'(busy), 0);
    repeat (120) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, epar(8'h5A));
    repeat (20) @(negedge clk);
    check_int("rst_mid_rcv", rcv_cnt - r0, 1);
    check_int("rst_mid_q", exp_q.size(), 0);
    ready = 1'b0;
  endtask

`ifdef IDLI_TB_UART_RX_PARITY_EN
  task automatic test_parity();
    int f0 = frame_cnt, r0 = rcv_cnt;
    ready = 1'b1;
    send_frame(8'h07, 0, 1'b0);
    repeat (20) @(negedge clk);
    check_int("par_bad_frame", frame_cnt - f0, 1);
    check_int("par_bad_rcv", rcv_cnt - r0, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 0, 1'b1);
    repeat (20) @(negedge clk);
    check_int("par_good_rcv", rcv_cnt - r0, 1);
    check_int("par_good_frame", frame_cnt - f0, 1);
    ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef IDLI_TB_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
